// File: rtl/mux_arb_reg_pkg.sv
// rtl/mux_arb_reg_pkg.sv - arbitration mode constants and width helper shared by arbitrated blocks
package mux_arb_reg_pkg;

   localparam int MUXARB_RR   = 0;
   localparam int MUXARB_PRIO = 1;

   // Smallest r with 2**r >= n; usable in parameter defaults.
   function automatic int muxarb_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// rtl/mux_arb_reg_rr_arbiter.sv - combinational round-robin / fixed-priority grant generator
module rr_arbiter
   import mux_arb_reg_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int MODE = MUXARB_RR,
   parameter int SELW = muxarb_clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx,
   output logic            any_grant
);

   logic [NCH-1:0]   mask;
   logic [2*NCH-1:0] dbl;

   // Lower copy keeps only channels at or above the pointer; upper copy provides the wrap.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NCH; i++)
         mask[i] = (MODE == MUXARB_PRIO) || (i >= int'(ptr));
      dbl = {req, req & mask};
   end

   // Lowest set bit of the doubled vector wins; fold its position back into 0..NCH-1.
   always_comb begin
      grant_idx = '0;
      any_grant = 1'b0;
      for (int j = 2*NCH-1; j >= 0; j--) begin
         if (dbl[j]) begin
            any_grant = 1'b1;
            grant_idx = SELW'(j % NCH);
         end
      end
      grant = any_grant ? (NCH'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - registered N:1 arbitrated multiplexer with valid/ready on every port
module mux_arb_reg
   import mux_arb_reg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCH   = 4,
   parameter int SELW  = muxarb_clog2(NCH),
   parameter int MODE  = MUXARB_RR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  grant_idx;
   logic [NCH-1:0]   grant;
   logic             any_grant;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(
      .NCH  (NCH),
      .MODE (MODE),
      .SELW (SELW)
   ) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Register accepts when empty or draining this cycle; nothing is accepted during reset.
   always_comb begin
      load_en  = (~out_valid | out_ready) & ~rst;
      in_ready = grant & {NCH{load_en}};
      xfer     = any_grant & load_en;
      sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
   end

   // Output word, its channel tag, and the round-robin pointer advance on each input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_chan  <= grant_idx;
         if (MODE == MUXARB_RR)
            rr_ptr <= (int'(grant_idx) == NCH-1) ? '0 : grant_idx + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N:1 multiplexer with built-in arbitration and a valid/ready handshake on every input and on the output. It generalises the fixed-width combinational 2:1, 4:1 and 8:1 selectors to any channel count and width. It adds round-robin or fixed-priority selection and a one-deep output register. It sits between several producers (prefetch, microcode, DMA-style requesters) and a single shared consumer such as a bus or register-file write port.

## Interface
- WIDTH, 16, data bits per channel (1..64)
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), width of channel index (derived, do not override)
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (channel 0 highest)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel request
- in_ready  out  NCH  per-channel accept; combinational
- out_data  out  WIDTH  registered selected data
- out_chan  out  SELW  index of the channel that produced out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- Definitions: transfer on a port = valid & ready in the same cycle; `load_en = ~out_valid | out_ready`.
- Grant (combinational, one-hot or zero):
  - MODE 0: the first requesting channel at or after `rr_ptr`, searching upward with wrap-around modulo NCH.
  - MODE 1: the lowest-index requesting channel.
- `in_ready[i] = grant[i] & load_en`. At most one in_ready is high per cycle.
- in_ready must never depend on out_valid of the same cycle other than through load_en.
- When an input transfer occurs, the output register loads the granted in_data, out_chan takes the index, and out_valid goes to 1 on the next edge.
- When out_ready=1 and there is no input transfer, out_valid goes to 0.
- Simultaneous output drain and input load: the register is reloaded and out_valid stays 1. There is no bubble, which gives full throughput of one word per cycle.
- When out_valid=1 and out_ready=0 (stall), out_data and out_chan hold and in_ready is all zero.
- rr_ptr (SELW bits) changes only on an input transfer, to (granted index + 1) mod NCH. For non-power-of-two NCH, index NCH-1 wraps to 0. In MODE 1, rr_ptr is unused and stays 0.
- A requester is not required to hold valid; the arbiter re-evaluates every cycle. in_data is sampled only on its transfer cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, rr_ptr=0, in_ready=0 while rst=1.
- Reset mid-operation: any held output word is discarded and out_valid is 0 on the cycle after the rst edge. Arbitration restarts at channel 0.
- Latency: input transfer in cycle N gives out_valid=1 with that data in cycle N+1.
- Throughput: 1 word/cycle while out_ready stays high.
- With no requesters: grant=0, in_ready=0, and out_valid falls once drained.
- Fairness: in MODE 0 with all NCH channels continuously valid, each channel is granted exactly once in every NCH consecutive transfers.

## Structure
- Shared include: MODE constants `MUXARB_RR=0` and `MUXARB_PRIO=1`, plus the clog2 helper function. Both are reused by future arbitrated blocks.
- One sub-module, `rr_arbiter`, with parameters NCH and MODE:
  - inputs: req[NCH], ptr[SELW]
  - outputs: grant[NCH] one-hot, grant_idx[SELW], any_grant
  - purely combinational; the implementation is the double-width masked priority-encoder technique.
- The top level contains the load_en logic, the output register, rr_ptr, and the index-driven data select.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid=1. Required: in_ready=0 and out_valid=0 throughout; the first grant after release goes to channel 0.
- Round-robin, NCH=4: in_valid=4'b1111, out_ready=1, in_data[i]=16'hA000+i. Required: out_chan sequence 0,1,2,3,0,1 with out_data A000..A003 repeating and out_valid=1 every cycle after the first.
- Fixed priority (MODE=1) with channels 1 and 3 valid. Required: only channel 1 is granted until it drops valid, then channel 3.
- Backpressure: hold out_ready=0 for 5 cycles while the output is loaded with 16'h1234. Required: out_data stays 16'h1234 and in_ready=0; on release, the next word loads in the same cycle as the drain.
- Non-power-of-two NCH=3: ptr wrap. Only channel 2 valid, then all valid. Required: grants 2,0,1,2 and rr_ptr never reaches 3.
- Mid-operation reset: assert rst while out_valid=1 and out_ready=0. Required: out_valid=0 on the next cycle and the held word is never delivered.
